// File: rtl/rave_backend_pkg.sv
// -----------------------------------------------------------------------------
// rave_backend_pkg
// Shared backend types: the decoded micro-op entry carried from decode to the
// mapper/rename stage, plus the field widths it is built from.
// The widths derive from the default NUM_UOPS / XLEN / ARCHFILE_SIZE values.
// The uop_queue parameters default to the same values and must stay in step.
// -----------------------------------------------------------------------------
package rave_backend_pkg;

    localparam int unsigned NUM_UOPS_DEF      = 32;
    localparam int unsigned XLEN_DEF          = 32;
    localparam int unsigned ARCHFILE_SIZE_DEF = 32;

    localparam int unsigned UOP_W  = $clog2(NUM_UOPS_DEF);
    localparam int unsigned IMM_W  = XLEN_DEF;
    localparam int unsigned ARCH_W = $clog2(ARCHFILE_SIZE_DEF);
    localparam int unsigned PC_W   = 32;

    typedef struct packed {
        logic [UOP_W-1:0]  uop;
        logic              eoi;
        logic [IMM_W-1:0]  imm;
        logic              use_imm;
        logic [PC_W-1:0]   pc;
        logic              except;
        logic [ARCH_W-1:0] src1_arch;
        logic [ARCH_W-1:0] src2_arch;
        logic [ARCH_W-1:0] dest_arch;
    } uop_entry_t;

endpackage : rave_backend_pkg

// File: rtl/uopq_storage.sv
// -----------------------------------------------------------------------------
// uopq_storage
// Entry array for uop_queue: one synchronous write port (at tail) and one
// asynchronous read port (at head). Pointer and occupancy control live in
// the parent.
// Ports:
//   clk        clock
//   wr_en_i    write the entry at wr_ptr_i on this edge
//   wr_ptr_i   write index (tail)
//   wr_data_i  entry to write
//   rd_ptr_i   read index (head)
//   rd_data_o  entry at rd_ptr_i, combinational
// -----------------------------------------------------------------------------
module uopq_storage
    import rave_backend_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr_i,
    input  uop_entry_t               wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
    output uop_entry_t               rd_data_o
);

    uop_entry_t mem_q [DEPTH];

    // NOTE: the array has no reset; entries are only visible once the count
    // covers them, so resetting them would add logic and buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_i];

endmodule : uopq_storage

// File: rtl/uop_queue.sv
// -----------------------------------------------------------------------------
// uop_queue
// Circular FIFO of decoded micro-ops between decode and the backend
// mapper/rename stage. It accepts one uop per cycle through enq_valid and
// enq_ready. It presents the oldest uop with uop_ready and holds it while the
// backend stalls. Flush or reset empties it.
// Optional feature macro: UOPQ_PERF_EN (stall-cycle counter and occupancy
// high-water mark). If the macro is undefined, both perf ports read 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enq_valid/ready     decode handshake; enq_ready depends on state only
//   enq_*               incoming uop payload
//   stall               backend cannot take a uop this cycle
//   flush               discard all entries (dominates enqueue and dequeue)
//   uop_ready           head uop is issued this cycle (no further ack)
//   uop..dest_arch      head payload, all zero while uop_ready=0
//   count               occupancy
//   perf_stall_cycles   saturating count of stalled cycles with data waiting
//   perf_max_count      occupancy high-water mark since reset
// -----------------------------------------------------------------------------
module uop_queue
    import rave_backend_pkg::*;
#(
    parameter int unsigned NUM_UOPS      = 32,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ARCHFILE_SIZE = 32,
    parameter int unsigned DEPTH         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enq_valid,
    output logic                             enq_ready,
    input  logic [$clog2(NUM_UOPS)-1:0]      enq_uop,
    input  logic                             enq_eoi,
    input  logic [XLEN-1:0]                  enq_imm,
    input  logic                             enq_use_imm,
    input  logic [31:0]                      enq_pc,
    input  logic                             enq_except,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] enq_src1_arch,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] enq_src2_arch,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] enq_dest_arch,
    input  logic                             stall,
    input  logic                             flush,
    output logic                             uop_ready,
    output logic [$clog2(NUM_UOPS)-1:0]      uop,
    output logic                             eoi,
    output logic [XLEN-1:0]                  imm,
    output logic                             use_imm,
    output logic [31:0]                      pc,
    output logic                             except,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] src1_arch,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] src2_arch,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] dest_arch,
    output logic [$clog2(DEPTH):0]           count,
    output logic [31:0]                      perf_stall_cycles,
    output logic [$clog2(DEPTH):0]           perf_max_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       empty, full;
    logic       enq_fire, deq_fire;
    uop_entry_t wr_entry, head_entry, out_entry;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // State-only: a dequeue in the same cycle does not open a slot until the
    // next cycle.
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready && !flush;

    // Gating with rst keeps a reset cycle from issuing the stale head.
    assign uop_ready = !empty && !stall && !flush && !rst;
    assign deq_fire  = uop_ready;

    assign wr_entry.uop       = enq_uop;
    assign wr_entry.eoi       = enq_eoi;
    assign wr_entry.imm       = enq_imm;
    assign wr_entry.use_imm   = enq_use_imm;
    assign wr_entry.pc        = enq_pc;
    assign wr_entry.except    = enq_except;
    assign wr_entry.src1_arch = enq_src1_arch;
    assign wr_entry.src2_arch = enq_src2_arch;
    assign wr_entry.dest_arch = enq_dest_arch;

    uopq_storage #(
        .DEPTH     (DEPTH)
    ) u_storage (
        .clk       (clk),
        .wr_en_i   (enq_fire),
        .wr_ptr_i  (tail_q),
        .wr_data_i (wr_entry),
        .rd_ptr_i  (head_q),
        .rd_data_o (head_entry)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            if (deq_fire) head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    // Payload is masked so the backend never sees a stale head.
    assign out_entry = uop_ready ? head_entry : '0;

    assign uop       = out_entry.uop;
    assign eoi       = out_entry.eoi;
    assign imm       = out_entry.imm;
    assign use_imm   = out_entry.use_imm;
    assign pc        = out_entry.pc;
    assign except    = out_entry.except;
    assign src1_arch = out_entry.src1_arch;
    assign src2_arch = out_entry.src2_arch;
    assign dest_arch = out_entry.dest_arch;

`ifdef UOPQ_PERF_EN
    logic [31:0]      stall_cycles_q;
    logic [CNT_W-1:0] max_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            max_count_q    <= '0;
        end else begin
            if (!empty && stall && !flush && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            // Tracks the next occupancy so the mark is current on the same edge.
            // Flush drives count_d to 0 and therefore never lowers it.
            if (count_d > max_count_q) begin
                max_count_q <= count_d;
            end
        end
    end

    assign perf_stall_cycles = stall_cycles_q;
    assign perf_max_count    = max_count_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_max_count    = '0;
`endif

endmodule : uop_queue
